// File: rtl/timex_if_pkg.sv
// Purpose : shared types and constants for the Timex FDD interface paging controller.
// Latency : n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package timex_if_pkg;

    // Paging FSM. The pending states hold the old memory map until the
    // current bus cycle has finished.
    typedef enum logic [1:0] {
        ST_OUT      = 2'd0,
        ST_IN_PEND  = 2'd1,
        ST_IN       = 2'd2,
        ST_OUT_PEND = 2'd3
    } page_state_t;

    // Bit positions in the control port register.
    localparam int FORCE_OUT = 7;   // self-clearing: force the map out
    localparam int TRAP_DIS  = 6;   // block the automatic page-in traps
    localparam int FORCE_IN  = 5;   // self-clearing: force the map in

    // Memory regions, given as the top address bits of each region.
    localparam logic [1:0] ZX_ROM_REGION = 2'b00;   // 0x0000-0x3FFF
    localparam logic [2:0] IF_ROM_REGION = 3'b000;  // 0x0000-0x1FFF
    localparam logic [2:0] IF_RAM_REGION = 3'b001;  // 0x2000-0x3FFF
    localparam int         REGION_AW     = 13;      // 8K window per region

    // Z80 control strobes, all active-low.
    typedef struct packed {
        logic iorq_n;
        logic mreq_n;
        logic rd_n;
        logic wr_n;
        logic m1_n;
    } zstrb_t;

    function automatic logic port_match(input logic [7:0] addr,
                                        input logic [7:0] port,
                                        input logic [7:0] mask);
        return (addr & mask) == (port & mask);
    endfunction

endpackage

// File: rtl/zbus_sync.sv
// Purpose : 2-FF synchroniser for the Z80 strobes plus a third stage for edge detection; A/D captured aligned with stage 2.
// Latency : levels valid 2 CLK after the pin changes; rise/fall pulses last one CLK.
// Backpressure: none; free-running sampler.
// Ports: clk/rst, bus_strb/bus_a/bus_d raw pins in; sync_lvl, sync_rise, sync_fall, sync_a, sync_d out.
module zbus_sync
    import timex_if_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  zstrb_t      bus_strb,
    input  logic [15:0] bus_a,
    input  logic [7:0]  bus_d,
    output zstrb_t      sync_lvl,
    output zstrb_t      sync_rise,
    output zstrb_t      sync_fall,
    output logic [15:0] sync_a,
    output logic [7:0]  sync_d
);

    zstrb_t      strb_s1, strb_s2, strb_s3;
    logic [15:0] a_s1;
    logic [7:0]  d_s1;

    // A and D go through the same two stages as the strobes so that a
    // decode on stage 2 always sees the address that belonged to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strb_s1 <= '1;
            strb_s2 <= '1;
            strb_s3 <= '1;
            a_s1    <= '0;
            sync_a  <= '0;
            d_s1    <= '0;
            sync_d  <= '0;
        end else begin
            strb_s1 <= bus_strb;
            strb_s2 <= strb_s1;
            strb_s3 <= strb_s2;
            a_s1    <= bus_a;
            sync_a  <= a_s1;
            d_s1    <= bus_d;
            sync_d  <= d_s1;
        end
    end

    assign sync_lvl  = strb_s2;
    assign sync_rise = zstrb_t'(strb_s2 & ~strb_s3);
    assign sync_fall = zstrb_t'(~strb_s2 & strb_s3);

endmodule

// File: rtl/timex_paging_ctrl.sv
// Purpose : Timex FDD interface paging FSM, control port latch, read buffer enable and chip selects.
// Latency : page change 3 CLK after the raw nMREQ rise; port write commits 3 CLK after the raw nWR rise.
// Backpressure: none; follows the Z80 bus, chip selects and nRD_OE are combinational from the pins.
// Ports: CLK/RST; Z80 bus A, D_IN, nIORQ/nMREQ/nRD/nWR/nM1 in;
//        nZX_ROMCS, nROM_CS, nRAM_CS, nRD_OE, CTRL_Q, PAGED out.
module timex_paging_ctrl
    import timex_if_pkg::*;
#(
    parameter int                         NUM_TRAPS    = 2,
    parameter logic [16*NUM_TRAPS-1:0]    TRAP_ADDRS   = {16'h0008, 16'h0000},
    parameter logic [15:0]                PAGEOUT_ADDR = 16'h0604,
    parameter logic [15:0]                PAGEOUT_MASK = 16'hFFFC,
    parameter logic [7:0]                 IO_PORT      = 8'h3F,
    parameter logic [7:0]                 IO_MASK      = 8'hFF,
    parameter int                         ROM_AW       = 12,
    parameter int                         RAM_AW       = 11
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] A,
    input  logic [7:0]  D_IN,
    input  logic        nIORQ,
    input  logic        nMREQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nM1,
    output logic        nZX_ROMCS,
    output logic        nROM_CS,
    output logic        nRAM_CS,
    output logic [7:0]  CTRL_Q,
    output logic        nRD_OE,
    output logic        PAGED
);

    // A device wider than its 8K window cannot be mapped; the echoes come
    // from simply not decoding the address bits above ROM_AW/RAM_AW.
    localparam bit ROM_FITS = (ROM_AW <= REGION_AW);
    localparam bit RAM_FITS = (RAM_AW <= REGION_AW);

    zstrb_t      sync_lvl, sync_rise, sync_fall;
    logic [15:0] sync_a;
    logic [7:0]  sync_d;
    logic        unused_sync;

    zbus_sync u_zbus_sync (
        .clk       (CLK),
        .rst       (RST),
        .bus_strb  ('{iorq_n: nIORQ, mreq_n: nMREQ, rd_n: nRD, wr_n: nWR, m1_n: nM1}),
        .bus_a     (A),
        .bus_d     (D_IN),
        .sync_lvl  (sync_lvl),
        .sync_rise (sync_rise),
        .sync_fall (sync_fall),
        .sync_a    (sync_a),
        .sync_d    (sync_d)
    );

    assign unused_sync = ^{sync_fall, sync_rise, sync_lvl};

    // Decodes on the synchronised bus.
    logic trap_hit, pageout_hit, port_wr;

    always_comb begin
        trap_hit = 1'b0;
        for (int i = 0; i < NUM_TRAPS; i++) begin
            if (sync_a == TRAP_ADDRS[16*i +: 16]) trap_hit = 1'b1;
        end
        trap_hit = trap_hit & ~sync_lvl.m1_n & ~sync_lvl.mreq_n;
    end

    assign pageout_hit = ~sync_lvl.mreq_n &
                         ((sync_a & PAGEOUT_MASK) == (PAGEOUT_ADDR & PAGEOUT_MASK));

    // nM1 high keeps interrupt acknowledge off the port.
    assign port_wr = port_match(sync_a[7:0], IO_PORT, IO_MASK) &
                     ~sync_lvl.iorq_n & sync_lvl.m1_n & ~sync_lvl.wr_n;

    page_state_t state;
    logic [7:0]  wr_dat;
    logic        wr_pend;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_OUT;
            PAGED   <= 1'b0;
            CTRL_Q  <= 8'h00;
            wr_dat  <= 8'h00;
            wr_pend <= 1'b0;
        end else begin
            // Keep tracking the data bus for the whole write; the last
            // value seen before nWR rises is the one that commits.
            if (port_wr) begin
                wr_dat  <= sync_d;
                wr_pend <= 1'b1;
            end else if (sync_rise.wr_n) begin
                wr_pend <= 1'b0;
            end

            if (wr_pend && sync_rise.wr_n) begin
                CTRL_Q <= wr_dat;
            end else if (CTRL_Q[FORCE_OUT] || CTRL_Q[FORCE_IN]) begin
                CTRL_Q[FORCE_OUT] <= 1'b0;
                CTRL_Q[FORCE_IN]  <= 1'b0;
            end

            if (CTRL_Q[FORCE_OUT]) begin
                state <= ST_OUT;
                PAGED <= 1'b0;
            end else if (CTRL_Q[FORCE_IN]) begin
                state <= ST_IN;
                PAGED <= 1'b1;
            end else begin
                case (state)
                    ST_OUT: begin
                        // Page-out beats a trap on the same address.
                        if (trap_hit && !pageout_hit && !CTRL_Q[TRAP_DIS])
                            state <= ST_IN_PEND;
                    end
                    ST_IN_PEND: begin
                        if (sync_rise.mreq_n) begin
                            state <= ST_IN;
                            PAGED <= 1'b1;
                        end
                    end
                    ST_IN: begin
                        if (pageout_hit) state <= ST_OUT_PEND;
                    end
                    ST_OUT_PEND: begin
                        if (sync_rise.mreq_n) begin
                            state <= ST_OUT;
                            PAGED <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_OUT;
                        PAGED <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Combinational outputs straight from the pins so the ROM/RAM see the
    // select within the same bus cycle.
    assign nRD_OE    = ~(port_match(A[7:0], IO_PORT, IO_MASK) & ~nIORQ & nM1 & ~nRD);
    assign nZX_ROMCS = ~(PAGED & (A[15:14] == ZX_ROM_REGION));
    assign nROM_CS   = ~(PAGED & ROM_FITS & (A[15:13] == IF_ROM_REGION) & ~nMREQ);
    assign nRAM_CS   = ~(PAGED & RAM_FITS & (A[15:13] == IF_RAM_REGION) & ~nMREQ);

endmodule

// File: tb/tb_timex_paging_ctrl.sv
module tb_timex_paging_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] A;
    logic [7:0]  D_IN;
    logic        nIORQ, nMREQ, nRD, nWR, nM1;
    logic        nZX_ROMCS, nROM_CS, nRAM_CS, nRD_OE, PAGED;
    logic [7:0]  CTRL_Q;

    int total = 0;
    int bad   = 0;

    // Bus-cycle level reference: paging state and control register.
    logic       m_paged;
    logic [7:0] m_ctrl;

    always #5 CLK = ~CLK;

    timex_paging_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .D_IN      (D_IN),
        .nIORQ     (nIORQ),
        .nMREQ     (nMREQ),
        .nRD       (nRD),
        .nWR       (nWR),
        .nM1       (nM1),
        .nZX_ROMCS (nZX_ROMCS),
        .nROM_CS   (nROM_CS),
        .nRAM_CS   (nRAM_CS),
        .CTRL_Q    (CTRL_Q),
        .nRD_OE    (nRD_OE),
        .PAGED     (PAGED)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_trap(input logic [15:0] a);
        return (a == 16'h0000) || (a == 16'h0008);
    endfunction

    function automatic bit is_pageout(input logic [15:0] a);
        return (a >= 16'h0604) && (a <= 16'h0607);
    endfunction

    function automatic bit port_hit(input logic [7:0] p);
        return p == 8'h3F;
    endfunction

    task automatic ticks(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic idle_bus();
        A     = 16'hFFFF;
        D_IN  = 8'h00;
        nIORQ = 1'b1;
        nMREQ = 1'b1;
        nRD   = 1'b1;
        nWR   = 1'b1;
        nM1   = 1'b1;
    endtask

    task automatic check_cs(input string tag);
        check_val({tag, ".zx"},  nZX_ROMCS, !(m_paged && A < 16'h4000));
        check_val({tag, ".rom"}, nROM_CS,   !(m_paged && A < 16'h2000 && !nMREQ));
        check_val({tag, ".ram"}, nRAM_CS,   !(m_paged && A >= 16'h2000 && A < 16'h4000 && !nMREQ));
    endtask

    // Memory read cycle, optionally an M1 opcode fetch.
    task automatic mem_cycle(input logic [15:0] addr, input bit m1);
        A = addr; nMREQ = 1'b0; nRD = 1'b0; nM1 = !m1;
        #1;
        check_cs("mem_cs");
        check_val("mem_rdoe", nRD_OE, 1'b1);
        ticks(4);
        check_val("mem_hold_paged", PAGED, m_paged);
        if (!m_paged) begin
            if (m1 && is_trap(addr) && !is_pageout(addr) && !m_ctrl[6]) m_paged = 1'b1;
        end else if (is_pageout(addr)) begin
            m_paged = 1'b0;
        end
        idle_bus();
        ticks(4);
        check_val("mem_paged", PAGED, m_paged);
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        A = {8'($urandom), port}; D_IN = data; nIORQ = 1'b0; nWR = 1'b0; nM1 = 1'b1;
        ticks(4);
        idle_bus();
        ticks(2);
        check_val("wr_early", CTRL_Q, m_ctrl);
        ticks(1);
        if (port_hit(port)) m_ctrl = data;
        check_val("wr_commit", CTRL_Q, m_ctrl);
        ticks(1);
        if (port_hit(port)) begin
            if (data[7])      m_paged = 1'b0;
            else if (data[5]) m_paged = 1'b1;
            m_ctrl = data & 8'h5F;
        end
        check_val("wr_ctrl", CTRL_Q, m_ctrl);
        check_val("wr_paged", PAGED, m_paged);
        ticks(1);
    endtask

    task automatic io_read(input logic [7:0] port, input bit int_ack);
        A = {8'($urandom), port}; nIORQ = 1'b0; nRD = 1'b0; nM1 = !int_ack;
        #1;
        check_val("rd_oe", nRD_OE, !(port_hit(port) && !int_ack));
        ticks(2);
        nRD = 1'b1;
        #1;
        check_val("rd_oe_off", nRD_OE, 1'b1);
        idle_bus();
        ticks(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".paged"}, PAGED,     1'b0);
        check_val({tag, ".ctrl"},  CTRL_Q,    8'h00);
        check_val({tag, ".zx"},    nZX_ROMCS, 1'b1);
        check_val({tag, ".rom"},   nROM_CS,   1'b1);
        check_val({tag, ".ram"},   nRAM_CS,   1'b1);
        check_val({tag, ".rdoe"},  nRD_OE,    1'b1);
    endtask

    logic [15:0] r_addr;
    logic [7:0]  r_port, r_data;
    int          r_op, r_sel;
    bit          r_m1;

    initial begin
        idle_bus();
        RST = 1'b1;
        A = 16'h0000; nMREQ = 1'b0;
        m_paged = 1'b0;
        m_ctrl  = 8'h00;
        ticks(3);
        check_reset_outputs("reset");
        idle_bus();
        ticks(2);
        RST = 1'b0;
        ticks(2);

        // Page in via trap, then interface ROM visible.
        mem_cycle(16'h0008, 1'b1);
        mem_cycle(16'h0000, 1'b0);
        // Page-out window, then RAM no longer selected.
        mem_cycle(16'h0605, 1'b0);
        mem_cycle(16'h2000, 1'b0);
        // Port writes, matching and not.
        io_write(8'h3F, 8'hA5);
        io_write(8'h7F, 8'h12);
        // Port reads and interrupt acknowledge.
        io_read(8'h3F, 1'b0);
        io_read(8'h3F, 1'b1);
        io_read(8'h3E, 1'b0);
        // Forced page-out and trap disable.
        mem_cycle(16'h0000, 1'b1);
        io_write(8'h3F, 8'h80);
        io_write(8'h3F, 8'h40);
        mem_cycle(16'h0000, 1'b1);
        mem_cycle(16'h0008, 1'b1);
        // Forced page-in, region edges and echoes.
        io_write(8'h3F, 8'h20);
        mem_cycle(16'h3FFF, 1'b0);
        mem_cycle(16'h1FFF, 1'b0);
        mem_cycle(16'h4000, 1'b0);
        mem_cycle(16'h0008, 1'b1);
        // Both force bits: out wins.
        io_write(8'h3F, 8'hA0);
        // Non-M1 read at a trap address does not page in.
        io_write(8'h3F, 8'h00);
        mem_cycle(16'h0008, 1'b0);

        for (int i = 0; i < 160; i++) begin
            r_op = $urandom_range(0, 9);
            if (r_op < 5) begin
                r_sel = $urandom_range(0, 4);
                r_m1  = $urandom_range(0, 1);
                case (r_sel)
                    0: begin
                        r_addr = ($urandom_range(0, 1) != 0) ? 16'h0008 : 16'h0000;
                        r_m1   = ($urandom_range(0, 3) != 0);
                    end
                    1: r_addr = 16'h0604 + 16'($urandom_range(0, 3));
                    2: r_addr = 16'($urandom_range(0, 16'h3FFF));
                    3: r_addr = 16'($urandom);
                    default: r_addr = 16'h0600 + 16'($urandom_range(0, 15));
                endcase
                mem_cycle(r_addr, r_m1);
            end else if (r_op < 8) begin
                r_port = ($urandom_range(0, 3) != 0) ? 8'h3F : 8'($urandom);
                r_data = 8'($urandom);
                if ($urandom_range(0, 1) != 0) r_data[6] = 1'b0;
                io_write(r_port, r_data);
            end else begin
                r_port = ($urandom_range(0, 1) != 0) ? 8'h3F : 8'($urandom);
                io_read(r_port, $urandom_range(0, 3) == 0);
            end
        end

        // Reset in the middle of a trap fetch discards the pending page-in.
        io_write(8'h3F, 8'h91);
        A = 16'h0008; nMREQ = 1'b0; nRD = 1'b0; nM1 = 1'b0;
        ticks(4);
        RST = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        m_paged = 1'b0;
        m_ctrl  = 8'h00;
        idle_bus();
        ticks(2);
        RST = 1'b0;
        ticks(5);
        check_val("post_rst_paged", PAGED, 1'b0);
        check_val("post_rst_ctrl", CTRL_Q, 8'h00);
        mem_cycle(16'h0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
